// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: FSM encoding,
// default widths and frame-buffer geometry.
package cam_pkg;

    // Frame buffer is four 512x32 RAM banks addressed as one word space.
    localparam int CAM_BANK_WORDS = 512;
    localparam int CAM_NUM_BANKS  = 4;
    localparam int CAM_ADDR_W     = $clog2(CAM_BANK_WORDS * CAM_NUM_BANKS);
    localparam int CAM_LINE_W     = 12;
    localparam int CAM_FRAME_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cam_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers the DVP VSYNC/HREF levels and produces single-cycle edge
// pulses by comparing the live level with the previous-cycle level.
module cam_sync_edge (
    input  logic PCLKI,
    input  logic WBs_RST_i,
    input  logic VSYNCI,
    input  logic HREFI,
    output logic vs_rise_o,
    output logic vs_fall_o,
    output logic hr_fall_o,
    output logic hr_q_o
);

    logic vs_q;
    logic hr_q;

    // Remember last cycle's frame/line levels for edge detection.
    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            vs_q <= 1'b0;
            hr_q <= 1'b0;
        end else begin
            vs_q <= VSYNCI;
            hr_q <= HREFI;
        end
    end

    assign vs_rise_o = VSYNCI & ~vs_q;
    assign vs_fall_o = ~VSYNCI & vs_q;
    assign hr_fall_o = ~HREFI & hr_q;
    assign hr_q_o    = hr_q;

endmodule

// File: rtl/cam_byte_packer.sv
// Camera capture front end: packs four DVP bytes per 32-bit word and
// writes them into the frame buffer, with frame/line status counters.
// Optional build macro CAM_TEST_PATTERN_EN replaces the camera data by a
// free-running 32-bit write counter (timing and strobes unchanged).
module cam_byte_packer
    import cam_pkg::*;
#(
    parameter int ADDR_W  = CAM_ADDR_W,
    parameter int LINE_W  = CAM_LINE_W,
    parameter int FRAME_W = CAM_FRAME_W
) (
    input  logic               PCLKI,
    input  logic               WBs_RST_i,
    input  logic               VSYNCI,
    input  logic               HREFI,
    input  logic [7:0]         CAM_D_i,
    input  logic               cap_arm_i,
    output logic               wr_en_o,
    output logic [ADDR_W-1:0]  wr_addr_o,
    output logic [31:0]        wr_data_o,
    output logic [1:0]         bank_o,
    output logic [LINE_W-1:0]  line_cnt_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic               frame_done_o,
    output logic               full_o,
    output logic               partial_o
);

    cam_state_e         state_q, state_d;
    logic               vs_rise, vs_fall, hr_fall, hr_q;
    logic               in_capture;

    logic [1:0]         k_q, k_d;
    logic [31:0]        pack_q, pack_d;
    logic               wr_en_q, wr_en_d;
    logic [31:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               filled_q, filled_d;
    logic               full_q, full_d;
    logic               partial_q, partial_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [FRAME_W-1:0] frame_q, frame_d;

    logic               byte_valid, line_end, frame_start, last_addr, buf_full;
    logic [31:0]        word_full, word_flush;

    cam_sync_edge u_sync (
        .PCLKI     (PCLKI),
        .WBs_RST_i (WBs_RST_i),
        .VSYNCI    (VSYNCI),
        .HREFI     (HREFI),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hr_fall_o (hr_fall),
        .hr_q_o    (hr_q)
    );

    // FSM state register.
    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
        if (WBs_RST_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    // FSM next state: only a fresh VSYNC rise starts a capture, so a frame
    // already running when armed is skipped; disarming never aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cap_arm_i) state_d = ST_WAIT;
            ST_WAIT:    if (vs_rise)   state_d = ST_CAPTURE;
            ST_CAPTURE: if (vs_fall)   state_d = ST_DONE;
            ST_DONE:    state_d = cap_arm_i ? ST_WAIT : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        in_capture   = (state_q == ST_CAPTURE);
        frame_done_o = (state_q == ST_DONE);
    end

    // Qualifiers; a VSYNC fall during an open line also closes that line.
    // The buffer counts as full already in the cycle of the last write.
    always_comb begin
        byte_valid  = in_capture & HREFI & VSYNCI;
        line_end    = in_capture & ((hr_fall & VSYNCI) | (vs_fall & hr_q));
        frame_start = (state_q == ST_WAIT) & vs_rise;
        last_addr   = (wr_addr_q == {ADDR_W{1'b1}});
        buf_full    = filled_q | (wr_en_q & last_addr);
    end

`ifdef CAM_TEST_PATTERN_EN
    logic [31:0] pat_q, pat_d;

    // Free-running pattern counter, advanced once per issued write.
    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
        if (WBs_RST_i) pat_q <= '0;
        else           pat_q <= pat_d;
    end

    // Every written word carries the counter, partial flushes included.
    always_comb begin
        word_full  = pat_q;
        word_flush = pat_q;
        pat_d      = wr_en_d ? pat_q + 32'd1 : pat_q;
    end
`else
    // Normal data: 4th byte lands on top; a flush keeps zeroed upper bytes.
    always_comb begin
        word_full  = {CAM_D_i, pack_q[23:0]};
        word_flush = pack_q;
    end
`endif

    // Packing, write strobe, address and status next-state logic.
    always_comb begin
        k_d       = k_q;
        pack_d    = pack_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        filled_d  = filled_q;
        full_d    = full_q;
        partial_d = partial_q;
        line_d    = line_q;
        frame_d   = frame_q;

        if (wr_en_q) begin
            if (last_addr) filled_d  = 1'b1;
            else           wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        if (frame_start) begin
            wr_addr_d = '0;
            line_d    = '0;
            full_d    = 1'b0;
            partial_d = 1'b0;
            filled_d  = 1'b0;
            k_d       = '0;
            pack_d    = '0;
        end else if (byte_valid) begin
            if (buf_full) begin
                full_d = 1'b1;
            end else if (k_q == 2'd3) begin
                wr_en_d   = 1'b1;
                wr_data_d = word_full;
                k_d       = '0;
                pack_d    = '0;
            end else begin
                pack_d[{k_q, 3'b000} +: 8] = CAM_D_i;
                k_d = k_q + 2'd1;
            end
        end else if (line_end) begin
            line_d = line_q + LINE_W'(1);
            if (k_q != 2'd0) begin
                partial_d = 1'b1;
                k_d       = '0;
                pack_d    = '0;
                if (!buf_full) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word_flush;
                end
            end
        end

        if (state_q == ST_DONE) frame_d = frame_q + FRAME_W'(1);
    end

    // Datapath registers; reset drops any half-packed word without writing.
    always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            k_q       <= '0;
            pack_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            filled_q  <= 1'b0;
            full_q    <= 1'b0;
            partial_q <= 1'b0;
            line_q    <= '0;
            frame_q   <= '0;
        end else begin
            k_q       <= k_d;
            pack_q    <= pack_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            filled_q  <= filled_d;
            full_q    <= full_d;
            partial_q <= partial_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign bank_o      = wr_addr_q[ADDR_W-1 -: 2];
    assign line_cnt_o  = line_q;
    assign frame_cnt_o = frame_q;
    assign full_o      = full_q;
    assign partial_o   = partial_q;

endmodule

// File: doc/cam_byte_packer.md
Name: cam_byte_packer

Overview:
- Capture-side front end for the camera path: samples the 8-bit DVP bus on PCLKI while the frame is active.
- Packs four consecutive bytes into one 32-bit word.
- Drives the word write port (address, data, enable) of the four 512x32 frame-buffer RAM banks.
- Also reports frame/line counters, bank select and a buffer-full status for the Wishbone status register.

Parameters:
- ADDR_W, 11, word address width; buffer depth = 2**ADDR_W words (2048 = 4 banks x 512).
- LINE_W, 12, width of the line counter.
- FRAME_W, 16, width of the frame counter.

Ports:
- PCLKI  in  1  camera pixel clock; all logic on its rising edge.
- WBs_RST_i  in  1  reset, asynchronous, active-high.
- VSYNCI  in  1  frame active (high during frame).
- HREFI  in  1  line active.
- CAM_D_i  in  8  pixel byte.
- cap_arm_i  in  1  level; arms capture of the next full frame (quasi-static, from WB register).
- wr_en_o  out  1  one-cycle word write strobe.
- wr_addr_o  out  ADDR_W  word address of the current write.
- wr_data_o  out  32  packed word; first byte in [7:0].
- bank_o  out  2  wr_addr_o[ADDR_W-1:ADDR_W-2]; selects RAM0..RAM3.
- line_cnt_o  out  LINE_W  lines completed in the current frame.
- frame_cnt_o  out  FRAME_W  frames completed; wraps.
- frame_done_o  out  1  one-cycle pulse at end of a captured frame.
- full_o  out  1  sticky: buffer filled and bytes were dropped.
- partial_o  out  1  sticky: a line ended on a non-multiple of 4 bytes.

Behaviour:
- Reset: all outputs 0; FSM = IDLE; byte index = 0; packing register = 0.
- Edge detect: VSYNCI and HREFI are registered each cycle.
  - Frame start = VSYNCI rising edge.
  - Frame end = VSYNCI falling edge.
  - Line end = HREFI falling edge while VSYNCI = 1.
- Valid byte = HREFI & VSYNCI in state CAPTURE.
- FSM:
  - IDLE: go to WAIT when cap_arm_i = 1.
  - WAIT: on frame-start edge go to CAPTURE; clear wr_addr_o, line_cnt_o, full_o and partial_o. A frame already in progress at arm time is skipped.
  - CAPTURE: pack bytes. On frame-end edge go to DONE.
  - DONE: pulse frame_done_o for 1 cycle, increment frame_cnt_o, go to WAIT if cap_arm_i = 1, otherwise IDLE.
  - cap_arm_i dropping mid-frame does not abort the frame.
- Packing:
  - Byte index k = 0..3; byte k goes to bits [8k+7:8k].
  - The cycle after the 4th valid byte is sampled: wr_en_o = 1, wr_data_o holds the word, wr_addr_o holds the current address. Latency = 1 PCLKI cycle after the last byte.
  - wr_addr_o increments the cycle after each write.
  - wr_data_o and wr_addr_o stay stable while wr_en_o is low.
- Line end with k != 0:
  - Flush: write the partial word with the unused upper bytes = 0, set partial_o, reset k = 0.
  - line_cnt_o increments on every line end, whether or not a flush occurs.
- Frame end while HREFI is still high: treat as a line end first (flush if k != 0, count the line), then go to DONE. Flush and frame_done_o pulse occur in the same cycle.
- Full:
  - After the write at address 2**ADDR_W-1, the address saturates; it does not wrap.
  - Further valid bytes are dropped, no writes are issued, and full_o is set until the next frame start.
- Reset asserted mid-frame: immediate return to the reset state, no flush. The next frame after re-arm starts at address 0.

Optional Feature:
- Macro CAM_TEST_PATTERN_EN.
- Defined: CAM_D_i is ignored. Each written word = a 32-bit free-running word counter, cleared by reset, incremented per write and not cleared per frame. A flushed partial word still carries the full counter value. Timing and strobes are identical.
- Undefined: normal packed camera data; no counter logic is synthesized.

Decomposition:
- Shared package cam_pkg holds:
  - FSM state encoding (IDLE, WAIT, CAPTURE, DONE; 2 bits).
  - Default ADDR_W, LINE_W, FRAME_W.
  - Bank size constant: 512 words.
- Sub-module cam_sync_edge: registers VSYNCI/HREFI and emits rise/fall pulses. It is natural and reusable by the RAM-side stage.

Test Plan:
- Arm, 1 frame of 2 lines x 8 bytes 0x01..0x10 → 4 writes: addr 0..3, data 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D; line_cnt_o = 2; frame_done_o once; frame_cnt_o = 1.
- Line of 6 bytes 0xA0..0xA5 → writes 0xA3A2A1A0, then 0x0000A5A4 on HREFI fall; partial_o = 1.
- Arm while VSYNCI already high → no writes until the next VSYNCI rise; first write at addr 0.
- Frame of 8200 bytes → 2048 writes; last at addr 0x7FF with bank_o = 3; full_o = 1; remaining bytes dropped; next frame clears full_o and restarts at 0.
- WBs_RST_i pulsed after 3 bytes mid-frame → all outputs 0 immediately; no write of the partial word.
- CAM_TEST_PATTERN_EN defined, two frames of 8 bytes → data 0,1 then 2,3 at addrs 0,1 in each frame.
